// File: rtl/mod_arith_pkg.sv
// Shared helpers for the end-around-carry modulo-(2^N-1) arithmetic family.
// Holds the residue word type, the all-ones (negative zero) constant and the
// end-around-carry add used by both the adder and subtractor datapaths.
package mod_arith_pkg;

    localparam int unsigned RES_W_MAX = 32;

    // Residue word, sized for the widest supported modulus; users truncate to N.
    typedef logic [RES_W_MAX-1:0] residue_t;

    // All-ones pattern of width n (2^n - 1), zero-extended to a residue word.
    function automatic residue_t mod_all_ones(input int unsigned n);
        return {RES_W_MAX{1'b1}} >> (RES_W_MAX - n);
    endfunction

    // Fold the carry back into the low n bits; cannot carry out a second time.
    function automatic residue_t eac_add(input residue_t sum, input logic cy,
                                         input int unsigned n);
        return (sum + residue_t'(cy)) & mod_all_ones(n);
    endfunction

endpackage

// File: rtl/eac_fixup.sv
// End-around-carry normalisation for modulo-(2^N-1) sums.
// Ports:
//   i_sum  - low N bits of the one's-complement sum
//   i_cy   - carry out of bit N-1
//   o_res  - normalised residue (all-ones mapped to 0 when CANON=1)
//   o_zero - residue is zero (either 0 or the all-ones negative zero)
module eac_fixup
    import mod_arith_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter bit          CANON = 1'b1
) (
    input  logic [N-1:0] i_sum,
    input  logic         i_cy,
    output logic [N-1:0] o_res,
    output logic         o_zero
);

    localparam logic [N-1:0] ALL_ONES = N'(mod_all_ones(N));

    logic [N-1:0] w_t;

    assign w_t = N'(eac_add(residue_t'(i_sum), i_cy, N));

    // Optional canonicalisation of negative zero.
    always_comb begin
        o_res = w_t;
        if (CANON && (w_t == ALL_ONES)) begin
            o_res = '0;
        end
    end

    assign o_zero = (w_t == '0) | (w_t == ALL_ONES);

endmodule

// File: rtl/mod_ones_sub_pipe.sv
// Two-stage pipelined modulo-(2^N-1) subtractor: diff = (a - b) mod (2^N-1),
// computed as a + ~b with end-around carry. Valid/ready on both sides.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - operand handshake (in_ready is combinational)
//   a, b                 - minuend, subtrahend
//   out_valid/out_ready  - result handshake
//   diff, zero           - registered result and zero-residue flag
module mod_ones_sub_pipe
    import mod_arith_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter bit          CANON = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         zero
);

    logic         r_s1_v;
    logic [N-1:0] r_s1_sum;
    logic         r_s1_cy;
    logic         r_s2_v;
    logic [N-1:0] r_diff;
    logic         r_zero;

    logic         w_s2_accept;
    logic         w_s1_accept;
    logic         w_in_hs;
    logic [N:0]   w_raw;
    logic [N-1:0] w_fix_res;
    logic         w_fix_zero;

    // A stage may load when it is empty or its contents move on this cycle.
    assign w_s2_accept = !r_s2_v | out_ready;
    assign w_s1_accept = !r_s1_v | w_s2_accept;
    assign in_ready    = w_s1_accept;
    assign w_in_hs     = in_valid & w_s1_accept;

    // One's-complement subtraction: a + ~b, keeping the carry for stage 2.
    assign w_raw = {1'b0, a} + {1'b0, ~b};

    eac_fixup #(
        .N     (N),
        .CANON (CANON)
    ) u_eac_fixup (
        .i_sum  (r_s1_sum),
        .i_cy   (r_s1_cy),
        .o_res  (w_fix_res),
        .o_zero (w_fix_zero)
    );

    // Stage 1: raw sum and carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v   <= 1'b0;
            r_s1_sum <= '0;
            r_s1_cy  <= 1'b0;
        end else if (w_s1_accept) begin
            r_s1_v <= w_in_hs;
            if (w_in_hs) begin
                r_s1_sum <= w_raw[N-1:0];
                r_s1_cy  <= w_raw[N];
            end
        end
    end

    // Stage 2: end-around carry, canonicalisation and zero detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_v <= 1'b0;
            r_diff <= '0;
            r_zero <= 1'b0;
        end else if (w_s2_accept) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_diff <= w_fix_res;
                r_zero <= w_fix_zero;
            end
        end
    end

    assign out_valid = r_s2_v;
    assign diff      = r_diff;
    assign zero      = r_zero;

endmodule

// File: tb/tb_mod_ones_sub_pipe.sv
// Directed bench for mod_ones_sub_pipe (N=8, modulus 255), CANON=1 and CANON=0
// instances driven in parallel.
module tb_mod_ones_sub_pipe;

    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         in_ready;
    logic         out_valid;
    logic [N-1:0] diff;
    logic         zero;
    logic         in_ready0;
    logic         out_valid0;
    logic [N-1:0] diff0;
    logic         zero0;

    int n_checks = 0;
    int n_errors = 0;
    int got      = 0;
    logic [15:0] q[$];

    always #5 clk = ~clk;

    mod_ones_sub_pipe #(.N(N), .CANON(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .zero      (zero)
    );

    mod_ones_sub_pipe #(.N(N), .CANON(1'b0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .a         (a),
        .b         (b),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .diff      (diff0),
        .zero      (zero0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: true residue difference, all-ones operand read as zero.
    function automatic int ref1(input logic [7:0] x, input logic [7:0] y);
        int rx;
        int ry;
        rx = (x == 8'hFF) ? 0 : int'(x);
        ry = (y == 8'hFF) ? 0 : int'(y);
        return (rx + 255 - ry) % 255;
    endfunction

    // Raw one's-complement result: zero residue shows as all-ones except 0 - 0xFF.
    function automatic int ref0(input logic [7:0] x, input logic [7:0] y);
        int r;
        r = ref1(x, y);
        if (r != 0) return r;
        return (x == 8'h00 && y == 8'hFF) ? 0 : 255;
    endfunction

    // Compare a result about to be handed off against the oldest queued input.
    task automatic collect(input string tag);
        logic [15:0] p;
        int e1;
        int e0;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check({tag, ".stray"}, 32'(diff), 32'hFFFF_FFFF);
            end else begin
                p  = q.pop_front();
                e1 = ref1(p[15:8], p[7:0]);
                e0 = ref0(p[15:8], p[7:0]);
                check({tag, ".diff"},  32'(diff),  32'(e1));
                check({tag, ".zero"},  32'(zero),  32'(e1 == 0));
                check({tag, ".diff0"}, 32'(diff0), 32'(e0));
                check({tag, ".zero0"}, 32'(zero0), 32'(e0 == 0 || e0 == 255));
            end
            got++;
        end
    endtask

    task automatic single(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                          input int ed, input int ez, input int ed0, input int ez0);
        a        = ta;
        b        = tb_v;
        in_valid = 1'b1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        check({tag, ".lat1"}, 32'(out_valid), 32'd0);
        cyc();
        check({tag, ".valid"},  32'(out_valid),  32'd1);
        check({tag, ".valid0"}, 32'(out_valid0), 32'd1);
        check({tag, ".diff"},   32'(diff),       32'(ed));
        check({tag, ".zero"},   32'(zero),       32'(ez));
        check({tag, ".diff0"},  32'(diff0),      32'(ed0));
        check({tag, ".zero0"},  32'(zero0),      32'(ez0));
        cyc();
        check({tag, ".done"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        @(negedge clk);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.diff",      32'(diff),      32'd0);
        check("rst.zero",      32'(zero),      32'd0);
        check("rst.in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        check("rel.out_valid", 32'(out_valid), 32'd0);
        check("rel.in_ready",  32'(in_ready),  32'd1);

        // Directed vectors: tag, a, b, diff, zero (CANON=1), diff, zero (CANON=0).
        single("v10m3",  8'd10,  8'd3,   7,   0, 7,   0);
        single("v3m10",  8'd3,   8'd10,  248, 0, 248, 0);
        single("v0m1",   8'd0,   8'd1,   254, 0, 254, 0);
        single("v55m55", 8'h55,  8'h55,  0,   1, 255, 1);
        single("vffm0",  8'hFF,  8'h00,  0,   1, 255, 1);
        single("v0mff",  8'h00,  8'hFF,  0,   1, 0,   1);
        single("v200m100", 8'd200, 8'd100, 100, 0, 100, 0);
        single("v100m200", 8'd100, 8'd200, 155, 0, 155, 0);

        // Full-rate stream.
        got = 0;
        for (int i = 0; i < 20; i++) begin
            collect("stream");
            if (i >= 2) check("stream.rate", 32'(out_valid), 32'd1);
            check("stream.in_ready", 32'(in_ready), 32'd1);
            a        = 8'($urandom_range(0, 255));
            b        = 8'($urandom_range(0, 255));
            in_valid = 1'b1;
            q.push_back({a, b});
            cyc();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            collect("stream");
            cyc();
        end
        check("stream.count", 32'(got), 32'd20);
        check("stream.left",  32'(q.size()), 32'd0);

        // Backpressure: three offered, two accepted, third held.
        out_ready = 1'b0;
        a = 8'd50; b = 8'd20; in_valid = 1'b1; q.push_back({a, b});
        cyc();
        check("bp.ready1", 32'(in_ready), 32'd1);
        a = 8'd20; b = 8'd50; q.push_back({a, b});
        cyc();
        check("bp.ready2", 32'(in_ready), 32'd0);
        a = 8'd7; b = 8'd7; q.push_back({a, b});
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("bp.full",  32'(in_ready),  32'd0);
            check("bp.valid", 32'(out_valid), 32'd1);
            check("bp.hold",  32'(diff),      32'd30);
        end
        out_ready = 1'b1;
        got = 0;
        collect("bp");
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            collect("bp");
            cyc();
        end
        check("bp.count", 32'(got), 32'd3);
        check("bp.left",  32'(q.size()), 32'd0);

        // Reset with both stages full.
        out_ready = 1'b0;
        a = 8'd9; b = 8'd4; in_valid = 1'b1;
        cyc();
        a = 8'd4; b = 8'd9;
        cyc();
        in_valid = 1'b0;
        check("mr.full",  32'(in_ready),  32'd0);
        check("mr.valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mr.drop",  32'(out_valid), 32'd0);
        check("mr.ready", 32'(in_ready),  32'd1);
        check("mr.diff",  32'(diff),      32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("mr.stale", 32'(out_valid), 32'd0);
        end
        single("mr.v1m2", 8'd1, 8'd2, 254, 0, 254, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
